// File: rtl/fp_recip_iter.sv
// fp_recip_iter: sequential IEEE-754 single-precision reciprocal.
// Newton-Raphson on the mantissa D in [0.5,1): seed N0 = 48/17 - 32/17*D,
// then N <- N*(2 - D*N). One shared Q2.FRAC_W multiplier and one subtractor
// are reused across the SEED / MUL_A / MUL_B states.
// Optional build macro: FP_RECIP_ROUND_NEAREST_EN (round-to-nearest-even on
// the packed mantissa; default build truncates).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE, and
// both are decoded from the state register alone, so neither depends
// combinationally on the opposite side's valid/ready. Once out_valid rises,
// out_data holds until it is taken.
module fp_recip_iter #(
  parameter int ITERS  = 3,
  parameter int FRAC_W = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int W = FRAC_W + 2;

  // Constants quantised to Q2.FRAC_W with truncation.
  localparam logic [63:0] C48_64 = (64'd48 << FRAC_W) / 64'd17;
  localparam logic [63:0] C32_64 = (64'd32 << FRAC_W) / 64'd17;
  localparam logic [W-1:0] C48_17 = C48_64[W-1:0];
  localparam logic [W-1:0] C32_17 = C32_64[W-1:0];
  localparam logic [W-1:0] TWO    = {2'b10, {FRAC_W{1'b0}}};
  localparam logic [2:0]   CNT_LAST = 3'(ITERS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    MUL_A = 3'd2,
    MUL_B = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]   d_q, n_q, t_q;
  logic [2:0]     cnt_q;
  logic           sign_q;
  logic [7:0]     exp_q;
  logic           m_zero_q;

  logic [7:0]     in_exp;
  logic [22:0]    in_man;
  logic           in_special;
  logic [31:0]    special_val;
  logic [W-1:0]   d_in;

  logic [W-1:0]   mul_a, mul_b, sub_min;
  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_t;
  logic [W-1:0]   diff;
  logic           last_iter;
  logic [31:0]    pack_val;

  // Bits of the full product that truncation discards.
  logic           unused_prod;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE) && (state != DONE);
  assign last_iter = (cnt_q == CNT_LAST);

  // Operand decode and special-value classification at the input.
  always_comb begin
    in_exp      = in_data[30:23];
    in_man      = in_data[22:0];
    in_special  = (in_exp == 8'hFF) || (in_exp == 8'h00);
    d_in        = {{(W-24){1'b0}}, 1'b1, in_man} << (FRAC_W - 24);
    special_val = {in_data[31], 8'hFF, 23'h0};
    if (in_exp == 8'hFF) begin
      if (in_man != 23'h0) special_val = 32'h7FC00000;
      else                 special_val = {in_data[31], 31'h0};
    end
  end

  // Shared multiplier/subtractor operand steering per state.
  always_comb begin
    mul_a   = n_q;
    mul_b   = t_q;
    sub_min = TWO;
    case (state)
      SEED: begin
        mul_a   = C32_17;
        mul_b   = d_q;
        sub_min = C48_17;
      end
      MUL_A: begin
        mul_a = d_q;
        mul_b = n_q;
      end
      default: ;
    endcase
  end

  assign prod        = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  assign prod_t      = prod[FRAC_W +: W];
  assign diff        = sub_min - prod_t;
  assign unused_prod = ^{prod[2*W-1:FRAC_W+W], prod[FRAC_W-1:0]};

  // Pack the final N (the product written on the last MUL_B) into IEEE form.
  always_comb begin
    logic signed [9:0] exp_raw;
    logic signed [9:0] exp_fin;
    logic [22:0]       mant;
`ifdef FP_RECIP_ROUND_NEAREST_EN
    logic [FRAC_W:0]   frac_ext;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       mant_sum;
`endif
    exp_raw  = (m_zero_q ? 10'sd254 : 10'sd253) - $signed({2'b00, exp_q});
    mant     = m_zero_q ? 23'h0 : prod_t[FRAC_W-1 -: 23];
    exp_fin  = exp_raw;
`ifdef FP_RECIP_ROUND_NEAREST_EN
    frac_ext = {prod_t[FRAC_W-1:0], 1'b0};
    guard    = frac_ext[FRAC_W-23];
    sticky   = |frac_ext[FRAC_W-24:0];
    round_up = !m_zero_q && guard && (sticky || mant[0]);
    mant_sum = {1'b0, mant} + {23'h0, round_up};
    mant     = mant_sum[22:0];
    exp_fin  = exp_raw + $signed({9'd0, mant_sum[23]});
`endif
    if (exp_fin <= 10'sd0) begin
      pack_val = {sign_q, 31'h0};
    end else if (exp_fin >= 10'sd255) begin
      pack_val = {sign_q, 8'hFF, 23'h0};
    end else begin
      pack_val = {sign_q, exp_fin[7:0], mant};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: specials jump straight to DONE, normals iterate.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = in_special ? DONE : SEED;
      SEED:    state_nxt = MUL_A;
      MUL_A:   state_nxt = MUL_B;
      MUL_B:   state_nxt = last_iter ? DONE : MUL_A;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: operand capture, iteration state, result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= '0;
      n_q      <= '0;
      t_q      <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      m_zero_q <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_data[31];
            exp_q    <= in_exp;
            m_zero_q <= (in_man == 23'h0);
            d_q      <= d_in;
            cnt_q    <= '0;
            if (in_special) out_data <= special_val;
          end
        end
        SEED:  n_q <= diff;
        MUL_A: t_q <= diff;
        MUL_B: begin
          n_q   <= prod_t;
          cnt_q <= cnt_q + 3'd1;
          if (last_iter) out_data <= pack_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_recip_iter.sv
// tb_fp_recip_iter: directed vector table plus handshake/reset corner cases
// for fp_recip_iter (ITERS=3, FRAC_W=30).
module tb_fp_recip_iter;

  localparam int ITERS    = 3;
  localparam int FRAC_W   = 30;
  localparam int NORM_LAT = 2 + 2 * ITERS;
  localparam int MAX_WAIT = 40;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    bit          special;
  } vec_t;

  vec_t vecs[19];

  fp_recip_iter #(.ITERS(ITERS), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand at a negedge; it is taken at the following posedge.
  task automatic drive_op(input string tag, input logic [31:0] x);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for the result, check latency/busy/data, then take it.
  task automatic collect(input string tag, input int exp_lat, input int exp_busy);
    int lat      = 0;
    int busy_cnt = 0;
    bit got      = 0;
    logic [31:0] exp_v;
    while (!got && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check({tag, "_data"}, out_data, exp_v);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int spurious;

`ifdef FP_RECIP_ROUND_NEAREST_EN
    vecs[0]  = '{32'h3FC00000, 32'h3F2AAAAB, 1'b0};  // 1.5
    vecs[1]  = '{32'h40400000, 32'h3EAAAAAB, 1'b0};  // 3.0
    vecs[2]  = '{32'h3FA00000, 32'h3F4CCCCD, 1'b0};  // 1.25
    vecs[3]  = '{32'h40A00000, 32'h3E4CCCCD, 1'b0};  // 5.0
    vecs[4]  = '{32'hC0A00000, 32'hBE4CCCCD, 1'b0};  // -5.0
`else
    vecs[0]  = '{32'h3FC00000, 32'h3F2AAAAA, 1'b0};
    vecs[1]  = '{32'h40400000, 32'h3EAAAAAA, 1'b0};
    vecs[2]  = '{32'h3FA00000, 32'h3F4CCCCC, 1'b0};
    vecs[3]  = '{32'h40A00000, 32'h3E4CCCCC, 1'b0};
    vecs[4]  = '{32'hC0A00000, 32'hBE4CCCCC, 1'b0};
`endif
    vecs[5]  = '{32'h40000000, 32'h3F000000, 1'b0};  // 2.0
    vecs[6]  = '{32'hC0800000, 32'hBE800000, 1'b0};  // -4.0
    vecs[7]  = '{32'h3F000000, 32'h40000000, 1'b0};  // 0.5
    vecs[8]  = '{32'h7E800000, 32'h00800000, 1'b0};  // 2^126 -> min normal
    vecs[9]  = '{32'h7E800001, 32'h00000000, 1'b0};  // just below min normal
    vecs[10] = '{32'h7F000001, 32'h00000000, 1'b0};  // underflow flush
    vecs[11] = '{32'h7F000000, 32'h00000000, 1'b0};  // 2^127 -> flush
    vecs[12] = '{32'h00000000, 32'h7F800000, 1'b1};  // +0
    vecs[13] = '{32'h80000000, 32'hFF800000, 1'b1};  // -0
    vecs[14] = '{32'h00000001, 32'h7F800000, 1'b1};  // denormal
    vecs[15] = '{32'hFF800000, 32'h80000000, 1'b1};  // -inf
    vecs[16] = '{32'h7F800000, 32'h00000000, 1'b1};  // +inf
    vecs[17] = '{32'h7FA00001, 32'h7FC00000, 1'b1};  // sNaN
    vecs[18] = '{32'hFFFFFFFF, 32'h7FC00000, 1'b1};  // negative NaN

    // Reset.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'h0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 19; i++) begin
      string tag;
      tag = $sformatf("v%0d_%h", i, vecs[i].din);
      exp_q.push_back(vecs[i].dout);
      drive_op(tag, vecs[i].din);
      collect(tag, vecs[i].special ? 1 : NORM_LAT, vecs[i].special ? 0 : NORM_LAT - 1);
    end

    // Back-pressure in DONE with a competing operand held on the input.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    @(posedge clk);
    #1 in_data = 32'hC0800000;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < MAX_WAIT);
    check("hold_latency", 32'(lat), 32'(NORM_LAT));
    for (int k = 0; k < 5; k++) begin
      check("hold_data",     out_data,            32'h3F000000);
      check("hold_in_ready", {31'd0, in_ready},   32'd0);
      check("hold_valid",    {31'd0, out_valid},  32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold_next_ready", {31'd0, in_ready},  32'd1);
    check("hold_next_valid", {31'd0, out_valid}, 32'd0);
    exp_q.push_back(32'hBE800000);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect("hold_next", NORM_LAT, NORM_LAT - 1);

    // Reset during MUL_A discards the operation.
    drive_op("abort", 32'h40000000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy",      {31'd0, busy},      32'd0);
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("abort_no_output", 32'(spurious), 32'd0);
    exp_q.push_back(32'h3F800000);
    drive_op("after_abort", 32'h3F800000);
    collect("after_abort", NORM_LAT, NORM_LAT - 1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
